// File: rtl/alu_operand_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_stage_if
//  Description : Decode-to-operand-stage instruction bus (valid/ready plus
//                instruction fields). The master is the decode side and the
//                slave is the operand stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_operand_stage_if #(
    parameter int NREGS = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic [2:0]               in_op;
    logic [$clog2(NREGS)-1:0] in_rd;
    logic [$clog2(NREGS)-1:0] in_ra;
    logic [$clog2(NREGS)-1:0] in_rb;
    logic                     in_use_imm;
    logic [15:0]              in_imm;
    logic                     in_wr_en;
    logic                     in_flags_en;

    modport master (
        output in_valid, in_op, in_rd, in_ra, in_rb,
               in_use_imm, in_imm, in_wr_en, in_flags_en,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_ra, in_rb,
               in_use_imm, in_imm, in_wr_en, in_flags_en,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_stage
//  Description : Operand-fetch / writeback stage around a combinational alu.
//                Holds the register file, forwards the in-flight result,
//                latches operands into the execute register and writes the
//                alu result and carry/zero flags back.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
    parameter int NREGS   = 8,
    parameter int R0_ZERO = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    alu_operand_stage_if.slave       bus,
    input  logic                     hold,
    output logic [2:0]               alu_op,
    output logic [15:0]              alu_a,
    output logic [15:0]              alu_b,
    input  logic [15:0]              alu_out,
    input  logic                     alu_carry,
    input  logic                     alu_zero,
    output logic                     flag_c,
    output logic                     flag_z,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [15:0]              dbg_data
);

    localparam int c_addr_w = $clog2(NREGS);

    logic [15:0]         r_regs [NREGS];
    logic                r_ex_valid;
    logic [c_addr_w-1:0] r_ex_rd;
    logic                r_ex_wr_en;
    logic                r_ex_flags_en;
    logic [2:0]          r_alu_op;
    logic [15:0]         r_alu_a;
    logic [15:0]         r_alu_b;
    logic                r_flag_c;
    logic                r_flag_z;

    logic                w_accept;
    logic                w_ex_writes;
    logic                w_retire;
    logic                w_wb_en;
    logic                w_ra_is_r0;
    logic                w_rb_is_r0;
    logic                w_fwd_a;
    logic                w_fwd_b;
    logic [15:0]         w_opnd_a;
    logic [15:0]         w_opnd_b;

    // Stall only from downstream; reset also blocks acceptance.
    assign bus.in_ready = ~hold & ~rst;
    assign w_accept     = bus.in_valid & bus.in_ready;

    // The ex instruction retires on any unheld edge; r0 writes are dropped
    // when r0 is hard-wired to zero.
    assign w_ex_writes = r_ex_valid & r_ex_wr_en;
    assign w_retire    = r_ex_valid & ~hold;
    assign w_wb_en     = w_retire & r_ex_wr_en &
                         ~((R0_ZERO != 0) && (r_ex_rd == '0));

    // Source operand selection: forwarding wins over the stale regfile copy,
    // except for a hard-wired r0 which always reads zero.
    assign w_ra_is_r0 = (R0_ZERO != 0) && (bus.in_ra == '0);
    assign w_rb_is_r0 = (R0_ZERO != 0) && (bus.in_rb == '0);
    assign w_fwd_a    = w_ex_writes && (r_ex_rd == bus.in_ra) && !w_ra_is_r0;
    assign w_fwd_b    = w_ex_writes && (r_ex_rd == bus.in_rb) && !w_rb_is_r0;

    assign w_opnd_a = w_fwd_a    ? alu_out :
                      w_ra_is_r0 ? 16'h0000 : r_regs[bus.in_ra];
    assign w_opnd_b = bus.in_use_imm ? bus.in_imm :
                      w_fwd_b        ? alu_out :
                      w_rb_is_r0     ? 16'h0000 : r_regs[bus.in_rb];

    // Execute register: load on accept, go idle otherwise; frozen under hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid    <= 1'b0;
            r_ex_rd       <= '0;
            r_ex_wr_en    <= 1'b0;
            r_ex_flags_en <= 1'b0;
            r_alu_op      <= 3'd0;
            r_alu_a       <= 16'h0000;
            r_alu_b       <= 16'h0000;
        end else if (!hold) begin
            if (w_accept) begin
                r_ex_valid    <= 1'b1;
                r_ex_rd       <= bus.in_rd;
                r_ex_wr_en    <= bus.in_wr_en;
                r_ex_flags_en <= bus.in_flags_en;
                r_alu_op      <= bus.in_op;
                r_alu_a       <= w_opnd_a;
                r_alu_b       <= w_opnd_b;
            end else begin
                r_ex_valid    <= 1'b0;
            end
        end
    end

    // Register file writeback of the retiring ex result.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= 16'h0000;
            end
        end else if (w_wb_en) begin
            r_regs[r_ex_rd] <= alu_out;
        end
    end

    // Architectural flags update from the retiring ex instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag_c <= 1'b0;
            r_flag_z <= 1'b0;
        end else if (w_retire && r_ex_flags_en) begin
            r_flag_c <= alu_carry;
            r_flag_z <= alu_zero;
        end
    end

    assign alu_op   = r_alu_op;
    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign flag_c   = r_flag_c;
    assign flag_z   = r_flag_z;
    assign dbg_data = r_regs[dbg_addr];

endmodule
`default_nettype wire
